mem_port_arbiter: RTL and testbench

//  Shares the single mem_cntrl request port (op/io_address/data bus/tx_done/rd_valid) among N DMA-style

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer that shares the single mem_cntrl request port among N_REQ clients.
// Optional per-grant watchdog is compiled in when MEM_ARB_WDOG_EN is defined.
module mem_port_arbiter #(
   parameter  int unsigned N_REQ       = 2,
   parameter  int unsigned WDOG_CYCLES = 1024,
   localparam int unsigned OP_W        = 2,
   localparam int unsigned ADDR_W      = 64,
   localparam int unsigned DATA_W      = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [OP_W*N_REQ-1:0]      req_op,
   input  logic [ADDR_W*N_REQ-1:0]    req_addr,
   input  logic [DATA_W*N_REQ-1:0]    req_wdata,
   output logic [N_REQ-1:0]           grant,
   output logic [N_REQ-1:0]           cli_tx_done,
   output logic [N_REQ-1:0]           cli_rd_valid,
   output logic [DATA_W-1:0]          cli_rdata,
   output logic [OP_W-1:0]            mem_op,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_tx_done,
   input  logic                       mem_rd_valid,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       busy,
   output logic                       wdog_abort
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("mem_port_arbiter: N_REQ must be in 2..8");
   end
   if (WDOG_CYCLES < 2) begin : g_bad_wdog
      $error("mem_port_arbiter: WDOG_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   w_grant_nxt;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   w_rr_ptr_nxt;
   logic [PTR_W:0]     w_idx;
   logic [PTR_W-1:0]   w_winner;
   logic               w_found;
   logic [N_REQ-1:0]   w_win_onehot;
   logic               w_expire;

`ifdef MEM_ARB_WDOG_EN
   localparam int unsigned CNT_W = $clog2(WDOG_CYCLES);
   logic [CNT_W-1:0]   r_wdog_cnt;
   logic [CNT_W-1:0]   w_wdog_cnt_nxt;

   // Expiry only when mem_cntrl has not completed in the same cycle.
   assign w_expire = (r_state == ST_BUSY) && (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) && !mem_tx_done;
`else
   assign w_expire = 1'b0;
`endif

   // Rotating priority search starting at r_rr_ptr.
   always_comb begin
      w_idx    = '0;
      w_winner = '0;
      w_found  = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_idx >= (PTR_W+1)'(N_REQ)) begin
            w_idx = w_idx - (PTR_W+1)'(N_REQ);
         end
         if (!w_found && req[w_idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[PTR_W-1:0];
         end
      end
      w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
`ifdef MEM_ARB_WDOG_EN
         r_wdog_cnt <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
`ifdef MEM_ARB_WDOG_EN
         r_wdog_cnt <= w_wdog_cnt_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_rr_ptr_nxt   = r_rr_ptr;
`ifdef MEM_ARB_WDOG_EN
      w_wdog_cnt_nxt = r_wdog_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt    = ST_BUSY;
               w_grant_nxt    = w_win_onehot;
               w_rr_ptr_nxt   = (w_winner == PTR_W'(N_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
`ifdef MEM_ARB_WDOG_EN
               w_wdog_cnt_nxt = '0;
`endif
            end
         end
         ST_BUSY: begin
            if (mem_tx_done || w_expire) begin
               w_state_nxt = ST_GAP;
               w_grant_nxt = '0;
            end else begin
`ifdef MEM_ARB_WDOG_EN
               w_wdog_cnt_nxt = r_wdog_cnt + CNT_W'(1);
`endif
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // Owner mux; an empty grant leaves every field at zero, so IDLE/GAP present op=00.
   always_comb begin
      mem_op       = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            mem_op    = req_op[i*OP_W +: OP_W];
            mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
      grant        = r_grant;
      cli_tx_done  = r_grant & {N_REQ{mem_tx_done | w_expire}};
      cli_rd_valid = r_grant & {N_REQ{mem_rd_valid}};
      cli_rdata    = (|r_grant) ? mem_rdata : '0;
      busy         = |r_grant;
      wdog_abort   = w_expire;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, burst sequences and a randomized run
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int N    = 2;
   localparam int WDOG = 8;
`ifdef MEM_ARB_WDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif
   localparam int BEATS = WD ? 4 : 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req;
   logic [3:0]    req_op;
   logic [127:0]  req_addr;
   logic [63:0]   req_wdata;
   logic [1:0]    grant;
   logic [1:0]    cli_tx_done;
   logic [1:0]    cli_rd_valid;
   logic [31:0]   cli_rdata;
   logic [1:0]    mem_op;
   logic [63:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_tx_done;
   logic          mem_rd_valid;
   logic [31:0]   mem_rdata;
   logic          busy;
   logic          wdog_abort;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.N_REQ(N), .WDOG_CYCLES(WDOG)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .grant(grant), .cli_tx_done(cli_tx_done),
      .cli_rd_valid(cli_rd_valid), .cli_rdata(cli_rdata), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_tx_done(mem_tx_done),
      .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .busy(busy), .wdog_abort(wdog_abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: current owner (-1 = none), one-cycle gap flag, next-priority client, cycles owned.
   int m_owner, m_ptr, m_wcnt;
   bit m_gap;

   function automatic void mdl_reset();
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_wcnt = 0;
   endfunction

   function automatic bit mdl_expire();
      return WD && (m_owner >= 0) && (m_wcnt == WDOG - 1) && !mem_tx_done;
   endfunction

   function automatic void mdl_step();
      if (m_owner >= 0) begin
         if (mem_tx_done || mdl_expire()) begin
            m_owner = -1; m_gap = 1'b1;
         end else begin
            m_wcnt++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (req != 2'b00) begin
         for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (req[c]) begin
               m_owner = c;
               break;
            end
         end
         m_ptr  = (m_owner + 1) % N;
         m_wcnt = 0;
      end
   endfunction

   task automatic mdl_check(input string tag);
      logic [1:0]  eg  = 2'b00;
      logic [1:0]  eop = 2'b00;
      logic [63:0] ead = '0;
      logic [31:0] ewd = '0;
      logic [31:0] erd = '0;
      bit          own = (m_owner >= 0);
      if (own) begin
         eg[m_owner] = 1'b1;
         eop = req_op[2*m_owner +: 2];
         ead = req_addr[64*m_owner +: 64];
         ewd = req_wdata[32*m_owner +: 32];
         erd = mem_rdata;
      end
      chk({tag, ".grant"},     64'(grant),        64'(eg));
      chk({tag, ".mem_op"},    64'(mem_op),       64'(eop));
      chk({tag, ".mem_addr"},  mem_addr,          ead);
      chk({tag, ".mem_wdata"}, 64'(mem_wdata),    64'(ewd));
      chk({tag, ".busy"},      64'(busy),         64'(own));
      chk({tag, ".tx_done"},   64'(cli_tx_done),  64'((mem_tx_done || mdl_expire()) ? eg : 2'b00));
      chk({tag, ".rd_valid"},  64'(cli_rd_valid), 64'(mem_rd_valid ? eg : 2'b00));
      chk({tag, ".rdata"},     64'(cli_rdata),    64'(erd));
      chk({tag, ".wdog"},      64'(wdog_abort),   64'(mdl_expire()));
   endtask

   // Inputs are set just after a rising edge; outputs are checked mid-cycle, then the edge consumes them.
   task automatic cyc(input string tag);
      #2;
      mdl_check(tag);
      @(posedge clk);
      if (rst_n) mdl_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mdl_reset();
      repeat (3) cyc("rst");
      rst_n = 1'b1;
   endtask

   int order[$];

   // Serve bursts of BEATS read beats plus tx_done for whoever owns the port; log owners in order.
   task automatic run_bursts(input logic [1:0] r, input int nb, input string tag);
      int beat = 0;
      order.delete();
      req = r;
      req_op = 4'b0101;
      for (int t = 0; t < 300 && order.size() < nb; t++) begin
         mem_rd_valid = (m_owner >= 0) && (beat < BEATS);
         mem_tx_done  = (m_owner >= 0) && (beat == BEATS);
         mem_rdata    = $urandom;
         if (mem_tx_done) order.push_back(m_owner);
         if (m_owner >= 0) beat = mem_tx_done ? 0 : beat + 1;
         cyc(tag);
      end
      mem_rd_valid = 1'b0;
      mem_tx_done  = 1'b0;
      chk({tag, ".bursts"}, 64'(order.size()), 64'(nb));
   endtask

   typedef struct {
      logic [1:0] req;
      logic [1:0] op0;
      logic [1:0] op1;
      logic       tx;
      logic       rv;
      logic [1:0] e_grant;
      logic [1:0] e_op;
      logic [1:0] e_ctx;
      logic [1:0] e_crv;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{2'b11, 2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[1]  = '{2'b11, 2'b01, 2'b11, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01};
      tbl[2]  = '{2'b11, 2'b01, 2'b11, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00};
      tbl[3]  = '{2'b10, 2'b01, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[4]  = '{2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[5]  = '{2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00};
      tbl[6]  = '{2'b11, 2'b01, 2'b11, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b10};
      tbl[7]  = '{2'b01, 2'b01, 2'b11, 1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00};
      tbl[8]  = '{2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 2'b10, 2'b11, 2'b10, 2'b10};
      tbl[9]  = '{2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[10] = '{2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[11] = '{2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      tbl[12] = '{2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00};
      tbl[13] = '{2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      tbl[14] = '{2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};

      req = 2'b11; req_op = 4'b1101; req_addr = {64'h400, 64'h100}; req_wdata = '0;
      mem_tx_done = 1'b0; mem_rd_valid = 1'b1; mem_rdata = 32'h1234_5678; rst_n = 1'b0;
      do_reset();

      // Directed table: owner mux, GAP, stray tx_done, owner dropping req mid-burst, nop forwarding.
      for (int i = 0; i < 15; i++) begin
         logic [63:0] ea;
         logic [31:0] ew;
         req          = tbl[i].req;
         req_op       = {tbl[i].op1, tbl[i].op0};
         req_addr     = {64'h400, 64'h100};
         req_wdata    = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
         mem_tx_done  = tbl[i].tx;
         mem_rd_valid = tbl[i].rv;
         mem_rdata    = 32'hC000_0000 | 32'(i);
         ea = tbl[i].e_grant[0] ? 64'h100 : (tbl[i].e_grant[1] ? 64'h400 : 64'h0);
         ew = tbl[i].e_grant[0] ? req_wdata[31:0] : (tbl[i].e_grant[1] ? req_wdata[63:32] : 32'h0);
         #2;
         chk($sformatf("v%0d.grant", i),    64'(grant),        64'(tbl[i].e_grant));
         chk($sformatf("v%0d.mem_op", i),   64'(mem_op),       64'(tbl[i].e_op));
         chk($sformatf("v%0d.addr", i),     mem_addr,          ea);
         chk($sformatf("v%0d.wdata", i),    64'(mem_wdata),    64'(ew));
         chk($sformatf("v%0d.busy", i),     64'(busy),         64'(|tbl[i].e_grant));
         chk($sformatf("v%0d.tx_done", i),  64'(cli_tx_done),  64'(tbl[i].e_ctx));
         chk($sformatf("v%0d.rd_valid", i), 64'(cli_rd_valid), 64'(tbl[i].e_crv));
         @(posedge clk);
         mdl_step();
         #1;
      end

      // Single-client read burst.
      req_addr = '0;
      run_bursts(2'b01, 1, "single");
      if (order.size() >= 1) chk("single.owner", 64'(order[0]), 64'd0);

      // Contention from reset: owners must alternate 0,1,0.
      req = 2'b11;
      do_reset();
      run_bursts(2'b11, 3, "contend");
      if (order.size() >= 3) begin
         chk("contend.o0", 64'(order[0]), 64'd0);
         chk("contend.o1", 64'(order[1]), 64'd1);
         chk("contend.o2", 64'(order[2]), 64'd0);
      end

      // Asynchronous reset while a grant is held: outputs drop without waiting for a clock.
      req = 2'b11; mem_tx_done = 1'b0; mem_rd_valid = 1'b0;
      for (int t = 0; t < 6 && m_owner < 0; t++) cyc("pre_rst");
      chk("pre_rst.busy", 64'(busy), 64'd1);
      mem_tx_done = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.grant",   64'(grant),       64'd0);
      chk("arst.busy",    64'(busy),        64'd0);
      chk("arst.mem_op",  64'(mem_op),      64'd0);
      chk("arst.tx_done", 64'(cli_tx_done), 64'd0);
      mdl_reset();
      @(posedge clk);
      #1;
      mem_tx_done = 1'b0;
      rst_n = 1'b1;

`ifdef MEM_ARB_WDOG_EN
      // Watchdog: owner never completes; abort on the WDOG-th owned cycle, then the other client wins.
      begin
         int nb = 0;
         int at = -1;
         req = 2'b11; req_op = 4'b0101;
         do_reset();
         for (int t = 0; t < 20; t++) begin
            #2;
            mdl_check("wdog");
            if (m_owner >= 0) nb++;
            if (wdog_abort === 1'b1 && at < 0) at = nb;
            @(posedge clk);
            mdl_step();
            #1;
         end
         chk("wdog.cycle", 64'(at), 64'(WDOG));
      end
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < N; c++) begin
            int v = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) req[c] = ~req[c];
            req_op[2*c +: 2] = (v == 0) ? 2'b00 : ((v == 1) ? 2'b01 : 2'b11);
         end
         req_addr     = {$urandom, $urandom, $urandom, $urandom};
         req_wdata    = {$urandom, $urandom};
         mem_tx_done  = ($urandom_range(0, 5) == 0);
         mem_rd_valid = $urandom_range(0, 1) == 1;
         mem_rdata    = $urandom;
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
